uart_tx_fifo_drain: RTL and testbench

UART transmitter that drains a first-word-fall-through byte FIFO and serialises each word onto a single TX line. Standard 8N1 framing with a configurable stop-bit count. Sits on the consumer side of the UART TX buffer: it pops the FIFO through its read strobe and drives the board TX pin.

---
 rtl/uart_tx_fifo_drain.sv | 128 ++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// 8N1-style UART transmitter that pops a first-word-fall-through FIFO and
// serialises each popped word LSB first, with 1 or 2 stop bits.
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick,
  output logic [1:0]            state_dbg
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic                  baud_wrap;
  logic                  last_stop;

  assign shift_next = shift_reg >> 1;
  assign baud_wrap  = (baud_cnt == BAUD_LAST);
  assign last_stop  = (stop_cnt == STOP_LAST);
  assign state_dbg  = state;

  // FIFO handshake: fifo_empty low means fifo_r_data is valid now; fifo_rd is
  // the ready/pop strobe, high only in IDLE while a word is present, so the
  // word transfers on the clock edge that ends that cycle. Held low in reset.
  assign fifo_rd = rst_n && (state == IDLE) && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift_reg    <= '0;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (!fifo_empty) begin
            shift_reg <= fifo_r_data;
            baud_cnt  <= '0;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_wrap) begin
            baud_cnt  <= '0;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end else begin
              tx <= shift_next[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          // Registered one cycle early so the pulse lands on the final stop cycle.
          tx_done_tick <= last_stop && (baud_cnt == BAUD_PRE);
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (last_stop) begin
              stop_cnt <= 1'b0;
              tx_busy  <= 1'b0;
              state    <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: one instance with 1 stop bit, one with
// 2 stop bits, each fed by a small FWFT FIFO model.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       empty1, empty2;
  logic [7:0] data1, data2;
  logic       rd1, tx1, busy1, tick1;
  logic       rd2, tx2, busy2, tick2;
  logic [1:0] st1, st2;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [3:0] log1[$];  // {tick, busy, rd, tx} per cycle
  logic [3:0] log2[$];
  logic       rd1_prev, rd2_prev;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(empty1), .fifo_r_data(data1),
    .fifo_rd(rd1), .tx(tx1), .tx_busy(busy1), .tx_done_tick(tick1), .state_dbg(st1)
  );

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(empty2), .fifo_r_data(data2),
    .fifo_rd(rd2), .tx(tx2), .tx_busy(busy2), .tx_done_tick(tick2), .state_dbg(st2)
  );

  // Expected line level at offset off after the pop cycle (off 0 = first start cycle).
  function automatic logic exp_tx(input logic [7:0] b, input int off);
    int slot;
    slot = off / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  function automatic int find_rd(input int which, input int from);
    int n;
    n = (which == 1) ? log1.size() : log2.size();
    for (int i = from; i < n; i++) begin
      if (which == 1 && log1[i][1]) return i;
      if (which == 2 && log2[i][1]) return i;
    end
    return -1;
  endfunction

  function automatic int count_bit(input int which, input int pos, input int from, input int to);
    int c;
    c = 0;
    for (int i = from; i <= to; i++) begin
      if (which == 1 && i < log1.size() && log1[i][pos]) c++;
      if (which == 2 && i < log2.size() && log2[i][pos]) c++;
    end
    return c;
  endfunction

  task automatic drive_inputs();
    empty1 = (q1.size() == 0);
    data1  = empty1 ? 8'h00 : q1[0];
    empty2 = (q2.size() == 0);
    data2  = empty2 ? 8'h00 : q2[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rd1_prev && q1.size() > 0) void'(q1.pop_front());
    if (rd2_prev && q2.size() > 0) void'(q2.pop_front());
    drive_inputs();
    #1;
    log1.push_back({tick1, busy1, rd1, tx1});
    log2.push_back({tick2, busy2, rd2, tx2});
    rd1_prev = rd1;
    rd2_prev = rd2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q1.delete();
    q2.delete();
    rd1_prev = 1'b0;
    rd2_prev = 1'b0;
    drive_inputs();
    step();
    step();
    rst_n = 1'b1;
    log1.delete();
    log2.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd1_prev = 1'b0;
    rd2_prev = 1'b0;
    q1.delete();
    q2.delete();
    q1.push_back(8'h11);
    q2.push_back(8'h22);
    drive_inputs();
    step();
    step();
    checks++; if (tx1 !== 1'b1) $display("FAIL reset_tx1 got %b want 1", tx1); else passes++;
    checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1 got %b want 0", busy1); else passes++;
    checks++; if (rd1 !== 1'b0) $display("FAIL reset_rd1 got %b want 0", rd1); else passes++;
    checks++; if (tick1 !== 1'b0) $display("FAIL reset_tick1 got %b want 0", tick1); else passes++;
    checks++; if (st1 !== 2'd0) $display("FAIL reset_state1 got %0d want 0", st1); else passes++;
    checks++; if (tx2 !== 1'b1) $display("FAIL reset_tx2 got %b want 1", tx2); else passes++;
    checks++; if (rd2 !== 1'b0) $display("FAIL reset_rd2 got %b want 0", rd2); else passes++;
    checks++; if (busy2 !== 1'b0) $display("FAIL reset_busy2 got %b want 0", busy2); else passes++;
  endtask

  task automatic test_single_frame();
    int t;
    do_reset();
    q1.push_back(8'hA5);
    run(60);
    t = find_rd(1, 0);
    checks++; if (t !== 0) $display("FAIL single_pop_cycle got %0d want 0", t); else passes++;
    checks++; if (count_bit(1, 1, 0, 59) !== 1) $display("FAIL single_pop_count got %0d want 1", count_bit(1, 1, 0, 59)); else passes++;
    if (t >= 0 && t <= 10) begin
      for (int off = 0; off < 40; off++) begin
        checks++;
        if (log1[t+1+off][0] !== exp_tx(8'hA5, off))
          $display("FAIL single_tx off=%0d got %b want %b", off, log1[t+1+off][0], exp_tx(8'hA5, off));
        else passes++;
      end
      for (int i = 0; i < 60; i++) begin
        checks++;
        if (log1[i][3] !== (i == t + 40))
          $display("FAIL single_tick cycle=%0d got %b want %b", i, log1[i][3], (i == t + 40));
        else passes++;
      end
      checks++; if (count_bit(1, 0, t+41, 59) !== 59 - t - 40) $display("FAIL single_tx_idle got %0d high want %0d", count_bit(1, 0, t+41, 59), 59 - t - 40); else passes++;
      checks++; if (count_bit(1, 2, t+1, t+40) !== 40) $display("FAIL single_busy got %0d want 40", count_bit(1, 2, t+1, t+40)); else passes++;
      checks++; if (log1[t+41][2] !== 1'b0) $display("FAIL single_busy_end got %b want 0", log1[t+41][2]); else passes++;
    end
  endtask

  task automatic test_idle();
    do_reset();
    run(1000);
    checks++; if (count_bit(1, 0, 0, 999) !== 1000) $display("FAIL idle_tx got %0d high want 1000", count_bit(1, 0, 0, 999)); else passes++;
    checks++; if (count_bit(1, 1, 0, 999) !== 0) $display("FAIL idle_rd got %0d pops want 0", count_bit(1, 1, 0, 999)); else passes++;
    checks++; if (count_bit(1, 2, 0, 999) !== 0) $display("FAIL idle_busy got %0d busy want 0", count_bit(1, 2, 0, 999)); else passes++;
  endtask

  task automatic test_back_to_back();
    int         t[3];
    logic [7:0] exp_b[3];
    logic [7:0] got;
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
    do_reset();
    for (int f = 0; f < 3; f++) q1.push_back(exp_b[f]);
    run(140);
    t[0] = find_rd(1, 0);
    t[1] = find_rd(1, t[0] + 1);
    t[2] = find_rd(1, t[1] + 1);
    checks++; if (count_bit(1, 1, 0, 139) !== 3) $display("FAIL b2b_pop_count got %0d want 3", count_bit(1, 1, 0, 139)); else passes++;
    checks++; if (t[1] - t[0] !== 41) $display("FAIL b2b_gap01 got %0d want 41", t[1] - t[0]); else passes++;
    checks++; if (t[2] - t[1] !== 41) $display("FAIL b2b_gap12 got %0d want 41", t[2] - t[1]); else passes++;
    if (t[0] >= 0 && t[2] > t[1] && t[1] > t[0] && t[2] + 42 < 140) begin
      for (int f = 0; f < 3; f++) begin
        got = 8'h00;
        for (int k = 0; k < 8; k++) got[k] = log1[t[f] + 1 + (k + 1) * CPB + CPB / 2][0];
        checks++; if (got !== exp_b[f]) $display("FAIL b2b_byte%0d got %h want %h", f, got, exp_b[f]); else passes++;
        checks++; if (log1[t[f] + 1][0] !== 1'b0) $display("FAIL b2b_start%0d got %b want 0", f, log1[t[f] + 1][0]); else passes++;
        checks++; if (log1[t[f] + 41][0] !== 1'b1) $display("FAIL b2b_idle_high%0d got %b want 1", f, log1[t[f] + 41][0]); else passes++;
        checks++; if (log1[t[f] + 41][2] !== 1'b0) $display("FAIL b2b_idle_busy%0d got %b want 0", f, log1[t[f] + 41][2]); else passes++;
      end
      checks++; if (log1[t[0] + 42][0] !== 1'b0) $display("FAIL b2b_next_start got %b want 0", log1[t[0] + 42][0]); else passes++;
    end
  endtask

  task automatic test_two_stop();
    int t, t2;
    do_reset();
    q2.push_back(8'h81);
    q2.push_back(8'h5A);
    run(100);
    t  = find_rd(2, 0);
    t2 = find_rd(2, t + 1);
    checks++; if (t !== 0) $display("FAIL stop2_pop_cycle got %0d want 0", t); else passes++;
    checks++; if (t2 - t !== 45) $display("FAIL stop2_next_pop got %0d want 45", t2 - t); else passes++;
    if (t >= 0 && t <= 10) begin
      for (int off = 0; off < 44; off++) begin
        checks++;
        if (log2[t+1+off][0] !== exp_tx(8'h81, off))
          $display("FAIL stop2_tx off=%0d got %b want %b", off, log2[t+1+off][0], exp_tx(8'h81, off));
        else passes++;
      end
      checks++; if (count_bit(2, 0, t+37, t+44) !== 8) $display("FAIL stop2_level got %0d high want 8", count_bit(2, 0, t+37, t+44)); else passes++;
      checks++; if (log2[t+44][3] !== 1'b1) $display("FAIL stop2_tick_at got %b want 1", log2[t+44][3]); else passes++;
      checks++; if (count_bit(2, 3, t+1, t+45) !== 1) $display("FAIL stop2_tick_count got %0d want 1", count_bit(2, 3, t+1, t+45)); else passes++;
      checks++; if (log2[t+45][0] !== 1'b1) $display("FAIL stop2_idle_high got %b want 1", log2[t+45][0]); else passes++;
      checks++; if (log2[t+46][0] !== 1'b0) $display("FAIL stop2_next_start got %b want 0", log2[t+46][0]); else passes++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    do_reset();
    q1.push_back(8'h3C);
    run(19);
    checks++; if (find_rd(1, 0) !== 0) $display("FAIL rst_mid_pop got %0d want 0", find_rd(1, 0)); else passes++;
    checks++; if (busy1 !== 1'b1) $display("FAIL rst_mid_busy_before got %b want 1", busy1); else passes++;
    checks++; if (st1 !== 2'd2) $display("FAIL rst_mid_state_before got %0d want 2", st1); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (tx1 !== 1'b1) $display("FAIL rst_mid_tx got %b want 1", tx1); else passes++;
    checks++; if (busy1 !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy1); else passes++;
    checks++; if (st1 !== 2'd0) $display("FAIL rst_mid_state got %0d want 0", st1); else passes++;
    rd1_prev = 1'b0;
    rd2_prev = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    base = log1.size();
    run(200);
    checks++; if (count_bit(1, 1, base, base + 199) !== 0) $display("FAIL rst_mid_repop got %0d pops want 0", count_bit(1, 1, base, base + 199)); else passes++;
    checks++; if (count_bit(1, 0, base, base + 199) !== 200) $display("FAIL rst_mid_tx_high got %0d want 200", count_bit(1, 0, base, base + 199)); else passes++;
  endtask

  task automatic test_late_arrival();
    int         t, t2;
    logic [7:0] got;
    do_reset();
    q1.push_back(8'h12);
    run(39);
    q1.push_back(8'h34);
    run(50);
    t  = find_rd(1, 0);
    t2 = find_rd(1, t + 1);
    checks++; if (t !== 0) $display("FAIL late_first_pop got %0d want 0", t); else passes++;
    checks++; if (t2 - t !== 41) $display("FAIL late_second_pop got %0d want 41", t2 - t); else passes++;
    if (t >= 0 && t <= 10 && t2 > t && t2 + 38 < log1.size()) begin
      checks++; if (count_bit(1, 1, t+1, t+40) !== 0) $display("FAIL late_early_pop got %0d want 0", count_bit(1, 1, t+1, t+40)); else passes++;
      checks++; if (log1[t+40][3] !== 1'b1) $display("FAIL late_tick got %b want 1", log1[t+40][3]); else passes++;
      got = 8'h00;
      for (int k = 0; k < 8; k++) got[k] = log1[t2 + 1 + (k + 1) * CPB + CPB / 2][0];
      checks++; if (got !== 8'h34) $display("FAIL late_byte got %h want 34", got); else passes++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_idle();
    test_back_to_back();
    test_two_stop();
    test_reset_mid_frame();
    test_late_arrival();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
